fetch_queue: RTL
================

# fetch_queue

Instruction fetch stage with a small decoupling queue, directly upstream of the decode-op translator. Owns the fetch PC, issues one-at-a-time instruction-bus requests, buffers returned words with their PC in a FIFO, and presents them to decode via a valid/ready handshake. Handles branch/exception redirects, including discarding an in-flight response, and flags misaligned fetch addresses (AdEL) without touching the bus.

## Interface
- RESET_PC, 32'hbfc0_0000: fetch address after reset.
- DEPTH, 4: FIFO entries (power of two, ≥2).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  32  request address (current PC).
- ireq_ready  in  1  bus accepts request this cycle (ireq_valid & ireq_ready = handshake).
- iresp_valid  in  1  response data valid; in order; never in the same cycle as the accepting handshake.
- iresp_data  in  32  returned instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC.
- out_valid  out  1  FIFO head valid to decode.
- out_instr  out  32  head instruction word.
- out_pc  out  32  head PC.
- out_adel  out  1  head is an address-error entry (out_instr = 0).
- out_ready  in  1  decode consumes head (out_valid & out_ready = pop).

## Operation
- State: pc[31:0], FIFO (DEPTH × {instr, pc, adel}), head/tail pointers and count (width clog2(DEPTH)+1), FSM {IDLE, WAIT, DROP}, halt flag.
- ireq_valid = (state==IDLE) & !halt & (count < DEPTH) & (pc[1:0]==0) & !redirect_valid; ireq_addr = pc always.
- IDLE: on handshake -> WAIT. If pc[1:0]!=0, !halt, count<DEPTH, no redirect: enqueue {instr=0, pc, adel=1}, set halt; no bus request.
- WAIT: on iresp_valid enqueue {iresp_data, pc, 0}, pc <= pc+4 (mod 2^32), -> IDLE.
- DROP: on iresp_valid discard data, -> IDLE. No request issued in WAIT/DROP (one outstanding max).
- halt: set only by AdEL entry; cleared only by redirect or reset. While set, no requests or enqueues.
- Redirect (highest priority): FIFO flushed (count=0, pointers reset), pc <= redirect_pc, halt <= 0; state WAIT->DROP, DROP stays DROP, IDLE stays IDLE. A pop or enqueue in the same cycle is cancelled. iresp_valid arriving in WAIT the same cycle as redirect is discarded and state -> IDLE.
- Pop and enqueue in same cycle: both occur, count unchanged. Pop on empty FIFO impossible (out_valid=0).
- Full (count==DEPTH): ireq_valid=0; since requests issue only when count<DEPTH and only one is outstanding, a response always has a free slot.

## Timing
- Reset values: pc=RESET_PC, count=0, state=IDLE, halt=0; during reset cycle ireq_valid=0, out_valid=0, out_adel=0.
- First cycle after reset: ireq_valid=1, ireq_addr=RESET_PC.
- out_valid = (count!=0), registered-state driven; out_* combinational from head entry. Enqueued word visible at out_* the cycle after iresp_valid.
- Minimum fetch period: 2 cycles per instruction (request, response), next request the cycle after response.
- Redirect in cycle t: out_valid=0 at t+1; if no request outstanding, ireq_valid=1 with ireq_addr=redirect_pc at t+1; if outstanding, first request the cycle after the dropped response.
- ireq_valid may drop without handshake only in a redirect cycle; otherwise held with stable address until accepted.
- No combinational path from iresp_* to out_*; redirect_valid -> ireq_valid is the only combinational input-to-output path.

## Test plan
- Reset, ireq_ready=1, 1-cycle response latency, out_ready=1: requests 0xbfc00000, 0xbfc00004, 0xbfc00008 -> decode sees those PCs in order with returned words, one per 2 cycles, out_adel=0.
- out_ready=0: after 4 responses count=4, ireq_valid stays 0; single pop -> ireq_valid=1 next cycle with next sequential PC.
- Redirect to 0x80001000 while in WAIT: FIFO empty next cycle, pending response data discarded (never at out_*), next request addr 0x80001000.
- Redirect to 0x80000002: one entry out_adel=1, out_pc=0x80000002, out_instr=0; no further requests until redirect to 0x80000100 resumes fetch there.
- Simultaneous pop and enqueue with count=2: count stays 2, ordering preserved; redirect same cycle as iresp_valid in WAIT: count=0, state IDLE next cycle.
- Assert reset while WAIT with 3 entries: next cycle out_valid=0, ireq_addr=RESET_PC; a stale iresp_valid after reset is not required to be handled (bus reset together).

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-bus request/response, redirect, and the
// decode-facing output handshake.
interface fetch_queue_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_adel;
  logic        out_ready;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_instr, out_pc, out_adel,
    input  ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_instr, out_pc, out_adel,
    output ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch with one outstanding bus request and a small decoupling
// FIFO of {instr, pc, adel} entries feeding decode.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic            halt_q, halt_d;

  logic   fetch_ok, req_ok, adel_enq, resp_enq, enq, pop, hs, we;
  entry_t enq_e, head_e;

  always_comb begin
    fetch_ok = (state_q == IDLE) && !halt_q && (count_q < DEPTH_C);
    req_ok   = fetch_ok && (pc_q[1:0] == 2'b00);
    adel_enq = fetch_ok && (pc_q[1:0] != 2'b00);
    resp_enq = (state_q == WAIT) && bus.iresp_valid;
    enq      = adel_enq || resp_enq;
    pop      = (count_q != '0) && bus.out_ready;
    hs       = bus.ireq_valid && bus.ireq_ready;
    we       = enq && !bus.redirect_valid;
    enq_e    = adel_enq ? '{instr: 32'h0, pc: pc_q, adel: 1'b1}
                        : '{instr: bus.iresp_data, pc: pc_q, adel: 1'b0};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    halt_d  = halt_q;
    if (bus.redirect_valid) begin
      // The in-flight response (if any) is stale; a response landing in the
      // redirect cycle itself retires it immediately.
      state_d = (state_q == IDLE || bus.iresp_valid) ? IDLE : DROP;
      pc_d    = bus.redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      halt_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (hs) state_d = WAIT;
        WAIT:    if (bus.iresp_valid) state_d = IDLE;
        DROP:    if (bus.iresp_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (pop) head_d = head_q + PW'(1);
      if (enq) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(pop);
      if (resp_enq) pc_d = pc_q + 32'd4;
      if (adel_enq) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      halt_q  <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we) fifo_q[tail_q] <= enq_e;
  end

  assign head_e         = fifo_q[head_q];
  assign bus.ireq_valid = req_ok && !bus.redirect_valid && !reset;
  assign bus.ireq_addr  = pc_q;
  assign bus.out_valid  = (count_q != '0) && !reset;
  assign bus.out_instr  = head_e.instr;
  assign bus.out_pc     = head_e.pc;
  assign bus.out_adel   = bus.out_valid && head_e.adel;
endmodule
